// File: rtl/three_wire_mc_pkg.sv
// Shared types and helpers for the three-wire serial master.
package three_wire_mc_pkg;

    // Frame sequencer states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_HOLD     = 3'd4,
        ST_GAP      = 3'd5
    } tw_state_t;

    // Index width for a select of n items, never narrower than one bit.
    function automatic int tw_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/three_wire_mc_tw_bit_timer.sv
// DIV-cycle phase timer: tick marks the last cycle of the current state.
// A clear on every state change restarts the count so each state lasts DIV cycles.
module tw_bit_timer #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV + 1);

    logic [CNT_W-1:0] cnt;

    // Down-counter, reloaded on state change or after reaching zero (never wraps).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || (cnt == '0)) begin
            cnt <= CNT_W'(DIV - 1);
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/three_wire_mc.sv
// Three-wire serial master: shifts one DATA_W-bit frame MSB-first to one of
// NUM_CS peripherals, with optional half-duplex readback on the shared SDIO pin.
// Handshake: start is a level request sampled only while busy=0; a request with
// an out-of-range cs_sel is answered by a one-cycle err pulse instead of a frame,
// and every accepted frame ends with exactly one done pulse.
module three_wire_mc
    import three_wire_mc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CMD_W  = 8,
    parameter int NUM_CS = 4,
    parameter int DIV    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          rd_nwr,
    input  logic [tw_clog2(NUM_CS)-1:0]   cs_sel,
    input  logic [DATA_W-1:0]             wdata,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [DATA_W-CMD_W-1:0]       rdata,
    output logic                          sclk,
    output logic [NUM_CS-1:0]             cs_n,
    output logic                          sdio_o,
    output logic                          sdio_oe,
    input  logic                          sdio_i
);

    localparam int CS_W  = tw_clog2(NUM_CS);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int RD_W  = DATA_W - CMD_W;

    tw_state_t state, next_state;

    logic              tick;
    logic              sel_ok;
    logic [DATA_W-2:0] shreg;      // bits still to send after the one on sdio_o
    logic              rd_q;
    logic [CS_W-1:0]   sel_q;
    logic [BIT_W-1:0]  bit_cnt;    // index of the bit currently on the wire
    logic [BIT_W-1:0]  bit_inc;
    logic              last_bit;
    logic [RD_W-1:0]   cap;

    logic              busy_d, done_d, err_d, sclk_d, sdio_o_d, sdio_oe_d, frame_cs;
    logic [NUM_CS-1:0] cs_n_d;
    logic [CS_W-1:0]   sel_d;

    assign sel_ok   = (int'(cs_sel) < NUM_CS);
    assign bit_inc  = (bit_cnt == BIT_W'(DATA_W)) ? bit_cnt : bit_cnt + 1'b1;
    assign last_bit = (bit_inc == BIT_W'(DATA_W));

    tw_bit_timer #(.DIV(DIV)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (next_state != state),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: each non-idle state lasts one timer period.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (start && sel_ok) next_state = ST_SETUP;
            ST_SETUP:    if (tick) next_state = ST_SHIFT_LO;
            ST_SHIFT_LO: if (tick) next_state = ST_SHIFT_HI;
            ST_SHIFT_HI: if (tick) next_state = last_bit ? ST_HOLD : ST_SHIFT_LO;
            ST_HOLD:     if (tick) next_state = ST_GAP;
            ST_GAP:      if (tick) next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered pins, derived from the transition.
    always_comb begin
        sel_d    = (state == ST_IDLE) ? cs_sel : sel_q;
        frame_cs = (next_state == ST_SETUP) || (next_state == ST_SHIFT_LO) ||
                   (next_state == ST_SHIFT_HI) || (next_state == ST_HOLD);
        busy_d   = (next_state != ST_IDLE);
        sclk_d   = (next_state == ST_SHIFT_HI);
        done_d   = (state == ST_HOLD) && (next_state == ST_GAP);
        err_d    = (state == ST_IDLE) && start && !sel_ok;
        for (int i = 0; i < NUM_CS; i++) begin
            cs_n_d[i] = !(frame_cs && (int'(sel_d) == i));
        end
        sdio_oe_d = sdio_oe;
        sdio_o_d  = sdio_o;
        if ((state == ST_IDLE) && (next_state == ST_SETUP)) begin
            sdio_oe_d = 1'b1;
            sdio_o_d  = wdata[DATA_W-1];
        end else if ((state == ST_SHIFT_HI) && (next_state == ST_SHIFT_LO)) begin
            if (rd_q && (bit_inc >= BIT_W'(CMD_W))) begin
                // Turnaround: release the pin to the peripheral for the data phase.
                sdio_oe_d = 1'b0;
                sdio_o_d  = 1'b0;
            end else begin
                sdio_o_d = shreg[DATA_W-2];
            end
        end else if ((next_state == ST_HOLD) || (next_state == ST_GAP) ||
                     (next_state == ST_IDLE)) begin
            sdio_oe_d = 1'b0;
            sdio_o_d  = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            sclk    <= 1'b0;
            cs_n    <= '1;
            sdio_o  <= 1'b0;
            sdio_oe <= 1'b0;
        end else begin
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            sclk    <= sclk_d;
            cs_n    <= cs_n_d;
            sdio_o  <= sdio_o_d;
            sdio_oe <= sdio_oe_d;
        end
    end

    // Frame datapath: request latch, shift/capture registers and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            rd_q    <= 1'b0;
            sel_q   <= '0;
            bit_cnt <= '0;
            cap     <= '0;
            rdata   <= '0;
        end else begin
            if ((state == ST_IDLE) && (next_state == ST_SETUP)) begin
                shreg   <= wdata[DATA_W-2:0];
                rd_q    <= rd_nwr;
                sel_q   <= cs_sel;
                bit_cnt <= '0;
            end
            if ((state == ST_SHIFT_HI) && tick) begin
                bit_cnt <= bit_inc;
                shreg   <= shreg << 1;
            end
            if ((state == ST_SHIFT_LO) && tick && rd_q && (bit_cnt >= BIT_W'(CMD_W))) begin
                cap <= RD_W'({cap, sdio_i});
            end
            if (done_d && rd_q) begin
                rdata <= cap;
            end
        end
    end

endmodule

// File: tb/tb_three_wire_mc.sv
// Bench for three_wire_mc: a default-parameter instance (a) and a DIV=1,
// DATA_W=24, NUM_CS=3 instance (b), checked against a frame-level model.
module tb_three_wire_mc;

    localparam int A_DW = 16, A_CW = 8, A_NCS = 4, A_DIV = 2;
    localparam int B_DW = 24, B_CW = 8, B_NCS = 3, B_DIV = 1;
    localparam int A_BUSY = A_DIV * (2 * A_DW + 3);
    localparam int B_BUSY = B_DIV * (2 * B_DW + 3);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance a ----------------
    logic        start_a = 1'b0, rd_a = 1'b0, sdio_i_a = 1'b0;
    logic [1:0]  sel_a = '0;
    logic [15:0] wdata_a = '0;
    logic        busy_a, done_a, err_a, sclk_a, sdio_o_a, sdio_oe_a;
    logic [7:0]  rdata_a;
    logic [3:0]  cs_n_a;

    three_wire_mc #(.DATA_W(A_DW), .CMD_W(A_CW), .NUM_CS(A_NCS), .DIV(A_DIV)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .rd_nwr(rd_a), .cs_sel(sel_a),
        .wdata(wdata_a), .busy(busy_a), .done(done_a), .err(err_a), .rdata(rdata_a),
        .sclk(sclk_a), .cs_n(cs_n_a), .sdio_o(sdio_o_a), .sdio_oe(sdio_oe_a), .sdio_i(sdio_i_a)
    );

    // ---------------- instance b ----------------
    logic        start_b = 1'b0, rd_b = 1'b0, sdio_i_b = 1'b0;
    logic [1:0]  sel_b = '0;
    logic [23:0] wdata_b = '0;
    logic        busy_b, done_b, err_b, sclk_b, sdio_o_b, sdio_oe_b;
    logic [15:0] rdata_b;
    logic [2:0]  cs_n_b;

    three_wire_mc #(.DATA_W(B_DW), .CMD_W(B_CW), .NUM_CS(B_NCS), .DIV(B_DIV)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .rd_nwr(rd_b), .cs_sel(sel_b),
        .wdata(wdata_b), .busy(busy_b), .done(done_b), .err(err_b), .rdata(rdata_b),
        .sclk(sclk_b), .cs_n(cs_n_b), .sdio_o(sdio_o_b), .sdio_oe(sdio_oe_b), .sdio_i(sdio_i_b)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    logic [0:0] exp_q[$];
    logic [0:0] obs_q[$];
    logic [7:0] model_rdata_a = '0;

    int         obs_busy, obs_done, obs_rises, obs_oe_fall, obs_err;
    logic [3:0] obs_cs;
    logic       obs_cs_bad, obs_timeout;
    logic [7:0] obs_rdata;

    // Expected bits at successive rising SCLK edges: the frame MSB-first, with
    // the pin released (driven 0) from bit cw onward in a read frame.
    task automatic push_frame_exp(input logic [47:0] w, input int dw, input int cw, input logic rd);
        for (int k = 0; k < dw; k++) begin
            exp_q.push_back((rd && k >= cw) ? 1'b0 : w[dw-1-k]);
        end
    endtask

    function automatic logic [47:0] pack_q(input logic [0:0] q[$]);
        logic [47:0] r;
        r = '0;
        foreach (q[i]) r = {r[46:0], q[i]};
        return r;
    endfunction

    // Driver/monitor for instance a: start must already be raised at a negedge.
    // Acts as the peripheral on reads, optionally re-pulses start mid-frame,
    // and optionally stops during SCLK-low of bit abort_at.
    task automatic obs_frame_a(input int inject_at, input logic [15:0] inject_data,
                               input int abort_at, input logic [7:0] resp);
        logic prev_sclk, seen_busy;
        obs_q.delete();
        obs_busy = 0; obs_done = 0; obs_rises = 0; obs_oe_fall = -1; obs_err = 0;
        obs_cs = 4'hF; obs_cs_bad = 1'b0; obs_timeout = 1'b1; obs_rdata = '0;
        prev_sclk = 1'b0; seen_busy = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (busy_a) begin obs_busy++; seen_busy = 1'b1; end
            if (err_a) obs_err++;
            if (done_a) begin obs_done++; obs_rdata = rdata_a; end
            if (sclk_a && !prev_sclk) begin obs_q.push_back(sdio_o_a); obs_rises++; end
            prev_sclk = sclk_a;
            if (busy_a && !sdio_oe_a && obs_oe_fall < 0) obs_oe_fall = obs_rises;
            if (cs_n_a != 4'hF) begin
                if (obs_cs == 4'hF) obs_cs = cs_n_a;
                else if (cs_n_a != obs_cs) obs_cs_bad = 1'b1;
            end
            if (!sclk_a && obs_rises >= A_CW && obs_rises < A_DW) sdio_i_a = resp[A_DW-1-obs_rises];
            if (inject_at > 0 && obs_busy == inject_at) begin start_a = 1'b1; wdata_a = inject_data; end
            if (abort_at >= 0 && obs_rises == abort_at && !sclk_a) begin obs_timeout = 1'b0; return; end
            if (seen_busy && !busy_a) begin obs_timeout = 1'b0; return; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, done_a, err_a, sclk_a, sdio_o_a, sdio_oe_a} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl_a got=%b exp=000000", {busy_a, done_a, err_a, sclk_a, sdio_o_a, sdio_oe_a});
        end
        checks++;
        if ({cs_n_a, rdata_a} !== {4'hF, 8'h00}) begin
            failures++; $display("FAIL reset_cs_rdata_a got=%h exp=f00", {cs_n_a, rdata_a});
        end
        checks++;
        if ({busy_b, done_b, err_b, sclk_b, sdio_o_b, sdio_oe_b, cs_n_b, rdata_b} !== {6'b0, 3'b111, 16'h0}) begin
            failures++; $display("FAIL reset_b got=%h exp=%h",
                {busy_b, done_b, err_b, sclk_b, sdio_o_b, sdio_oe_b, cs_n_b, rdata_b}, {6'b0, 3'b111, 16'h0});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Fixed write and read vectors first, then randomized frames.
    task automatic test_frames();
        logic [15:0] w;
        logic        rd;
        logic [1:0]  sel;
        logic [7:0]  resp, exp_rdata;
        logic [3:0]  exp_cs;
        for (int n = 0; n < 10; n++) begin
            if (n == 0) begin
                w = 16'h55F0; rd = 1'b0; sel = 2'd0; resp = 8'h00;
            end else if (n == 1) begin
                w = {8'hA5, 8'($urandom)}; rd = 1'b1; sel = 2'd2; resp = 8'h3C;
            end else begin
                w = 16'($urandom); rd = 1'($urandom_range(0, 1)); sel = 2'($urandom_range(0, 3));
                resp = 8'($urandom);
            end
            exp_q.delete();
            push_frame_exp({32'h0, w}, A_DW, A_CW, rd);
            exp_cs    = ~(4'b0001 << sel);
            exp_rdata = rd ? resp : model_rdata_a;
            @(negedge clk);
            wdata_a = w; rd_a = rd; sel_a = sel; start_a = 1'b1;
            obs_frame_a(0, 16'h0, -1, resp);
            checks++;
            if (obs_timeout !== 1'b0) begin failures++; $display("FAIL frame_timeout n=%0d got=1 exp=0", n); end
            checks++;
            if (obs_busy != A_BUSY) begin failures++; $display("FAIL frame_busy n=%0d got=%0d exp=%0d", n, obs_busy, A_BUSY); end
            checks++;
            if (obs_done != 1) begin failures++; $display("FAIL frame_done n=%0d got=%0d exp=1", n, obs_done); end
            checks++;
            if (obs_q.size() != exp_q.size() || pack_q(obs_q) !== pack_q(exp_q)) begin
                failures++; $display("FAIL frame_bits n=%0d got=%h/%0d exp=%h/%0d", n,
                    pack_q(obs_q), obs_q.size(), pack_q(exp_q), exp_q.size());
            end
            checks++;
            if (obs_cs !== exp_cs || obs_cs_bad) begin
                failures++; $display("FAIL frame_cs_n n=%0d got=%b unstable=%0d exp=%b", n, obs_cs, obs_cs_bad, exp_cs);
            end
            checks++;
            if (obs_oe_fall != (rd ? A_CW : A_DW)) begin
                failures++; $display("FAIL frame_oe_fall n=%0d got=%0d exp=%0d", n, obs_oe_fall, rd ? A_CW : A_DW);
            end
            checks++;
            if (obs_rdata !== exp_rdata || rdata_a !== exp_rdata) begin
                failures++; $display("FAIL frame_rdata n=%0d got=%h/%h exp=%h", n, obs_rdata, rdata_a, exp_rdata);
            end
            checks++;
            if (obs_err != 0) begin failures++; $display("FAIL frame_err n=%0d got=%0d exp=0", n, obs_err); end
            model_rdata_a = exp_rdata;
        end
    endtask

    task automatic test_ignore_start();
        logic [15:0] w;
        int extra;
        w = 16'($urandom);
        exp_q.delete();
        push_frame_exp({32'h0, w}, A_DW, A_CW, 1'b0);
        @(negedge clk);
        wdata_a = w; rd_a = 1'b0; sel_a = 2'd3; start_a = 1'b1;
        obs_frame_a(10, ~w, -1, 8'h00);
        checks++;
        if (obs_q.size() != exp_q.size() || pack_q(obs_q) !== pack_q(exp_q)) begin
            failures++; $display("FAIL ignore_bits got=%h exp=%h", pack_q(obs_q), pack_q(exp_q));
        end
        checks++;
        if (obs_done != 1 || obs_busy != A_BUSY) begin
            failures++; $display("FAIL ignore_done_busy got=%0d/%0d exp=1/%0d", obs_done, obs_busy, A_BUSY);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy_a || cs_n_a !== 4'hF) extra++;
        end
        checks++;
        if (extra != 0) begin failures++; $display("FAIL ignore_no_requeue got=%0d exp=0", extra); end
    endtask

    task automatic test_err();
        @(negedge clk);
        sel_b = 2'd3; wdata_b = 24'($urandom); start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        checks++;
        if ({err_b, busy_b, sclk_b, cs_n_b} !== {3'b100, 3'b111}) begin
            failures++; $display("FAIL err_pulse got=%b exp=100111", {err_b, busy_b, sclk_b, cs_n_b});
        end
        @(negedge clk);
        checks++;
        if ({err_b, busy_b, sclk_b, cs_n_b} !== {3'b000, 3'b111}) begin
            failures++; $display("FAIL err_one_cycle got=%b exp=000111", {err_b, busy_b, sclk_b, cs_n_b});
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] w;
        logic [1:0]  sel;
        w = 16'($urandom);
        @(negedge clk);
        wdata_a = w; rd_a = 1'b0; sel_a = 2'd1; start_a = 1'b1;
        obs_frame_a(0, 16'h0, 7, 8'h00);
        checks++;
        if (obs_rises != 7 || obs_timeout !== 1'b0) begin
            failures++; $display("FAIL midreset_reach got=%0d exp=7", obs_rises);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cs_n_a, sclk_a, busy_a, sdio_oe_a, sdio_o_a} !== {4'hF, 4'b0000}) begin
            failures++; $display("FAIL midreset_outputs got=%b exp=11110000", {cs_n_a, sclk_a, busy_a, sdio_oe_a, sdio_o_a});
        end
        checks++;
        if (rdata_a !== 8'h00) begin failures++; $display("FAIL midreset_rdata got=%h exp=00", rdata_a); end
        model_rdata_a = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        w = 16'($urandom); sel = 2'($urandom_range(0, 3));
        exp_q.delete();
        push_frame_exp({32'h0, w}, A_DW, A_CW, 1'b0);
        wdata_a = w; rd_a = 1'b0; sel_a = sel; start_a = 1'b1;
        obs_frame_a(0, 16'h0, -1, 8'h00);
        checks++;
        if (obs_q.size() != exp_q.size() || pack_q(obs_q) !== pack_q(exp_q)) begin
            failures++; $display("FAIL postreset_bits got=%h exp=%h", pack_q(obs_q), pack_q(exp_q));
        end
        checks++;
        if (obs_busy != A_BUSY || obs_done != 1 || obs_cs !== ~(4'b0001 << sel)) begin
            failures++; $display("FAIL postreset_frame got=%0d/%0d/%b exp=%0d/1/%b",
                obs_busy, obs_done, obs_cs, A_BUSY, ~(4'b0001 << sel));
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] w;
        logic [1:0]  sel;
        logic [2:0]  exp_cs;
        int          runs[2];
        int          run_idx, cur, gap_cnt, gap_obs, dones, extra;
        logic        seen_low, prev_sclk, cs_bad, finished;
        w = 24'($urandom); sel = 2'($urandom_range(0, 2)); exp_cs = ~(3'b001 << sel);
        exp_q.delete(); obs_q.delete();
        push_frame_exp({24'h0, w}, B_DW, B_CW, 1'b0);
        push_frame_exp({24'h0, w}, B_DW, B_CW, 1'b0);
        runs[0] = 0; runs[1] = 0; run_idx = 0; cur = 0; gap_cnt = 0; gap_obs = -1; dones = 0;
        seen_low = 1'b0; prev_sclk = 1'b0; cs_bad = 1'b0; finished = 1'b0;
        @(negedge clk);
        wdata_b = w; sel_b = sel; rd_b = 1'b0; start_b = 1'b1;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            @(negedge clk);
            if (done_b) dones++;
            if (sclk_b && !prev_sclk) obs_q.push_back(sdio_o_b);
            prev_sclk = sclk_b;
            if (cs_n_b == 3'b111) begin
                if (seen_low) gap_cnt++;
            end else begin
                if (seen_low && gap_cnt > 0) gap_obs = gap_cnt;
                gap_cnt = 0; seen_low = 1'b1;
                if (cs_n_b !== exp_cs) cs_bad = 1'b1;
            end
            if (busy_b) cur++;
            else if (cur > 0) begin
                runs[run_idx] = cur; run_idx++; cur = 0;
                if (run_idx == 2) begin start_b = 1'b0; finished = 1'b1; end
            end
        end
        checks++;
        if (!finished) begin failures++; $display("FAIL b2b_timeout got=%0d frames exp=2", run_idx); end
        checks++;
        if (runs[0] != B_BUSY || runs[1] != B_BUSY) begin
            failures++; $display("FAIL b2b_busy got=%0d,%0d exp=%0d", runs[0], runs[1], B_BUSY);
        end
        checks++;
        if (gap_obs != B_DIV + 1) begin failures++; $display("FAIL b2b_cs_gap got=%0d exp=%0d", gap_obs, B_DIV + 1); end
        checks++;
        if (dones != 2) begin failures++; $display("FAIL b2b_done got=%0d exp=2", dones); end
        checks++;
        if (obs_q.size() != exp_q.size() || pack_q(obs_q) !== pack_q(exp_q) || cs_bad) begin
            failures++; $display("FAIL b2b_bits got=%h/%0d cs_bad=%0d exp=%h/%0d",
                pack_q(obs_q), obs_q.size(), cs_bad, pack_q(exp_q), exp_q.size());
        end
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy_b) extra++;
        end
        checks++;
        if (extra != 0) begin failures++; $display("FAIL b2b_stop got=%0d exp=0", extra); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_frames();
        test_ignore_start();
        test_err();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
